// File: rtl/slave_fifo_responder_if.sv
// slave_fifo_responder_if: slave-FIFO control/flag lines plus the host-side port.
// FD stays a plain inout on the responder so the tristate bus resolves at top level.
interface slave_fifo_responder_if;
    logic        SLOE;
    logic        SLRD;
    logic        SLWR;
    logic [1:0]  FIFOADR;
    logic        PKTEND;
    logic        FLAG_EMPTY;
    logic        FLAG_FULL;
    logic [15:0] HOST_WR_DATA;
    logic        HOST_WR;
    logic        HOST_WR_READY;
    logic [15:0] HOST_RD_DATA;
    logic        HOST_RD_VALID;
    logic        HOST_RD;
    logic [15:0] FRAME_COUNT;
    logic        FRAME_ERR;
    logic        OVERFLOW;
    logic        UNDERFLOW;

    modport master (
        output SLOE, SLRD, SLWR, FIFOADR, PKTEND, HOST_WR_DATA, HOST_WR, HOST_RD,
        input  FLAG_EMPTY, FLAG_FULL, HOST_WR_READY, HOST_RD_DATA, HOST_RD_VALID,
               FRAME_COUNT, FRAME_ERR, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  SLOE, SLRD, SLWR, FIFOADR, PKTEND, HOST_WR_DATA, HOST_WR, HOST_RD,
        output FLAG_EMPTY, FLAG_FULL, HOST_WR_READY, HOST_RD_DATA, HOST_RD_VALID,
               FRAME_COUNT, FRAME_ERR, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/slave_fifo_responder.sv
// slave_fifo_responder: device side of the slave-FIFO link with OUT/IN endpoints,
// host port, packet commit and an on-the-fly IN frame parser.
module slave_fifo_responder #(
    parameter int          DEPTH     = 256,
    parameter int          AW        = 8,
    parameter int          PKT_WORDS = 256,
    parameter logic [15:0] PREFIX    = 16'hAA55
) (
    input  logic                  CLK,
    input  logic                  RST,
    inout  wire  [15:0]           FD,
    slave_fifo_responder_if.slave bus
);
    typedef enum logic [1:0] {HUNT, HDR, PAY} pstate_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PKT_CNT  = (AW+1)'(PKT_WORDS);

    logic [15:0]   out_mem [DEPTH];
    logic [15:0]   in_mem  [DEPTH];
    logic [AW-1:0] out_wr_ptr, out_rd_ptr, in_wr_ptr, in_rd_ptr;
    logic [AW:0]   out_count, in_unc, in_com, unc_next;
    logic          out_sel, in_sel, m_rd, m_wr, h_wr, h_rd, commit;
    pstate_t       pstate;
    logic [7:0]    remaining;

    assign out_sel = bus.FIFOADR == 2'b00;
    assign in_sel  = bus.FIFOADR == 2'b10;

    assign bus.FLAG_EMPTY    = out_count == '0;
    assign bus.FLAG_FULL     = in_unc + in_com == FULL_CNT;
    assign bus.HOST_WR_READY = out_count != FULL_CNT;
    assign bus.HOST_RD_VALID = in_com != '0;
    assign bus.HOST_RD_DATA  = in_mem[in_rd_ptr];

    assign FD = (bus.SLOE && out_sel) ? (bus.FLAG_EMPTY ? 16'h0000 : out_mem[out_rd_ptr]) : 16'hzzzz;

    assign m_rd = bus.SLRD && out_sel && !bus.FLAG_EMPTY;
    assign m_wr = bus.SLWR && in_sel && !bus.FLAG_FULL;
    assign h_wr = bus.HOST_WR && bus.HOST_WR_READY;
    assign h_rd = bus.HOST_RD && bus.HOST_RD_VALID;

    // A write on the same edge as PKTEND or the filling write is included in the commit
    assign unc_next = in_unc + (AW+1)'(m_wr);
    assign commit   = unc_next == PKT_CNT || (bus.PKTEND && unc_next != '0);

    always_ff @(posedge CLK) begin
        if (h_wr) out_mem[out_wr_ptr] <= bus.HOST_WR_DATA;
        if (m_wr) in_mem[in_wr_ptr] <= FD;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_wr_ptr    <= '0;
            out_rd_ptr    <= '0;
            out_count     <= '0;
            in_wr_ptr     <= '0;
            in_rd_ptr     <= '0;
            in_unc        <= '0;
            in_com        <= '0;
            bus.OVERFLOW  <= 1'b0;
            bus.UNDERFLOW <= 1'b0;
        end else begin
            out_wr_ptr <= out_wr_ptr + AW'(h_wr);
            out_rd_ptr <= out_rd_ptr + AW'(m_rd);
            out_count  <= out_count + (AW+1)'(h_wr) - (AW+1)'(m_rd);
            in_wr_ptr  <= in_wr_ptr + AW'(m_wr);
            in_rd_ptr  <= in_rd_ptr + AW'(h_rd);
            in_unc     <= commit ? '0 : unc_next;
            in_com     <= (commit ? in_com + unc_next : in_com) - (AW+1)'(h_rd);
            if ((bus.SLWR && in_sel && bus.FLAG_FULL) || (bus.HOST_WR && !bus.HOST_WR_READY))
                bus.OVERFLOW <= 1'b1;
            if ((bus.SLRD && out_sel && bus.FLAG_EMPTY) || (bus.HOST_RD && !bus.HOST_RD_VALID))
                bus.UNDERFLOW <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pstate          <= HUNT;
            remaining       <= '0;
            bus.FRAME_COUNT <= '0;
            bus.FRAME_ERR   <= 1'b0;
        end else begin
            bus.FRAME_ERR <= 1'b0;
            if (m_wr) begin
                case (pstate)
                    HUNT: begin
                        if (FD == PREFIX) pstate <= HDR;
                        else bus.FRAME_ERR <= 1'b1;
                    end
                    HDR: begin
                        if (FD[15:13] != 3'b000) begin
                            bus.FRAME_ERR <= 1'b1;
                            pstate        <= HUNT;
                        end else if (FD[7:0] == 8'd0) begin
                            bus.FRAME_COUNT <= bus.FRAME_COUNT + 16'd1;
                            pstate          <= HUNT;
                        end else begin
                            remaining <= FD[7:0];
                            pstate    <= PAY;
                        end
                    end
                    default: begin
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            bus.FRAME_COUNT <= bus.FRAME_COUNT + 16'd1;
                            pstate          <= HUNT;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_slave_fifo_responder.sv
// tb_slave_fifo_responder: directed test-plan sequences then randomized traffic,
// every cycle compared against a queue-based model of both endpoints and the framing rules.
module tb_slave_fifo_responder;
    localparam int          DEPTH     = 256;
    localparam int          PKT_WORDS = 256;
    localparam logic [15:0] PREFIX    = 16'hAA55;

    logic        CLK;
    logic        RST;
    wire  [15:0] FD;
    logic        fd_oe;
    logic [15:0] fd_val;

    slave_fifo_responder_if bus();

    slave_fifo_responder #(.DEPTH(DEPTH), .AW(8), .PKT_WORDS(PKT_WORDS), .PREFIX(PREFIX)) dut (
        .CLK(CLK),
        .RST(RST),
        .FD(FD),
        .bus(bus)
    );

    assign FD = fd_oe ? fd_val : 16'hzzzz;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    logic [15:0] out_q[$];
    logic [15:0] in_c[$];
    logic [15:0] in_p[$];
    logic [15:0] fr[$];
    logic [15:0] exp_fc;
    logic        exp_err, exp_ov, exp_ud;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic idle();
        bus.SLOE = 0; bus.SLRD = 0; bus.SLWR = 0; bus.FIFOADR = 2'b00; bus.PKTEND = 0;
        bus.HOST_WR = 0; bus.HOST_WR_DATA = 16'h0; bus.HOST_RD = 0;
    endtask

    task automatic model_reset();
        out_q.delete(); in_c.delete(); in_p.delete(); fr.delete();
        exp_fc = 0; exp_err = 0; exp_ov = 0; exp_ud = 0;
    endtask

    // Frame judged on the whole word list collected since the last frame boundary
    task automatic parse(input logic [15:0] w);
        logic [15:0] h;
        fr.push_back(w);
        if (fr[0] != PREFIX) begin
            exp_err = 1; fr.delete();
        end else if (fr.size() >= 2) begin
            h = fr[1];
            if (h[15:13] != 0) begin
                exp_err = 1; fr.delete();
            end else if (fr.size() == int'(h[7:0]) + 2) begin
                exp_fc = exp_fc + 16'd1; fr.delete();
            end
        end
    endtask

    task automatic compare();
        chk("flag_empty", bus.FLAG_EMPTY, out_q.size() == 0);
        chk("flag_full", bus.FLAG_FULL, in_c.size() + in_p.size() == DEPTH);
        chk("host_wr_ready", bus.HOST_WR_READY, out_q.size() < DEPTH);
        chk("host_rd_valid", bus.HOST_RD_VALID, in_c.size() > 0);
        if (in_c.size() > 0) chk("host_rd_data", bus.HOST_RD_DATA, in_c[0]);
        if (bus.SLOE && bus.FIFOADR == 2'b00) chk("fd", FD, out_q.size() > 0 ? out_q[0] : 16'h0);
        chk("frame_count", bus.FRAME_COUNT, exp_fc);
        chk("frame_err", bus.FRAME_ERR, exp_err);
        chk("overflow", bus.OVERFLOW, exp_ov);
        chk("underflow", bus.UNDERFLOW, exp_ud);
    endtask

    task automatic model_edge();
        bit o_ne, o_rdy, i_full, i_val;
        o_ne   = out_q.size() > 0;
        o_rdy  = out_q.size() < DEPTH;
        i_full = in_c.size() + in_p.size() == DEPTH;
        i_val  = in_c.size() > 0;
        exp_err = 0;
        if (bus.SLRD && bus.FIFOADR == 2'b00) begin
            if (o_ne) void'(out_q.pop_front()); else exp_ud = 1;
        end
        if (bus.HOST_WR) begin
            if (o_rdy) out_q.push_back(bus.HOST_WR_DATA); else exp_ov = 1;
        end
        if (bus.SLWR && bus.FIFOADR == 2'b10) begin
            if (!i_full) begin in_p.push_back(fd_val); parse(fd_val); end
            else exp_ov = 1;
        end
        if (bus.HOST_RD) begin
            if (i_val) void'(in_c.pop_front()); else exp_ud = 1;
        end
        if (in_p.size() == PKT_WORDS || (bus.PKTEND && in_p.size() > 0)) begin
            foreach (in_p[i]) in_c.push_back(in_p[i]);
            in_p.delete();
        end
    endtask

    task automatic tick();
        fd_oe = !(bus.SLOE && bus.FIFOADR == 2'b00);
        #1;
        compare();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
        idle();
    endtask

    task automatic mw(input logic [15:0] w);
        bus.SLWR = 1; bus.FIFOADR = 2'b10; fd_val = w;
        tick();
    endtask

    task automatic drain();
        while (in_p.size() > 0 || in_c.size() > 0) begin
            if (in_c.size() == 0) begin bus.PKTEND = 1; bus.FIFOADR = 2'b10; end
            else bus.HOST_RD = 1;
            tick();
        end
    endtask

    function automatic logic [15:0] rand_word();
        case ($urandom % 4)
            0: return PREFIX;
            1: return {8'h00, 8'($urandom % 4)};
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        fd_val = 0;
        fd_oe  = 1;
        RST    = 1;
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 0;
        compare();

        // OUT endpoint: host pushes, master pops with FD presenting the head word
        bus.HOST_WR = 1; bus.HOST_WR_DATA = 16'h1111; tick();
        bus.HOST_WR = 1; bus.HOST_WR_DATA = 16'h2222; tick();
        bus.SLOE = 1; tick();
        bus.SLOE = 1; bus.SLRD = 1; tick();
        bus.SLOE = 1; bus.SLRD = 1; tick();
        chk("tp_empty_after_pops", bus.FLAG_EMPTY, 1);
        chk("tp_no_underflow_yet", bus.UNDERFLOW, 0);
        bus.SLOE = 1; bus.SLRD = 1; tick();
        chk("tp_underflow", bus.UNDERFLOW, 1);

        // Good frame, held uncommitted until PKTEND
        mw(PREFIX); mw(16'h1003); mw(16'h000A); mw(16'h000B); mw(16'h000C);
        chk("tp_fc_one", bus.FRAME_COUNT, 1);
        chk("tp_valid_before_pktend", bus.HOST_RD_VALID, 0);
        bus.PKTEND = 1; bus.FIFOADR = 2'b10; tick();
        chk("tp_valid_after_pktend", bus.HOST_RD_VALID, 1);
        chk("tp_first_word", bus.HOST_RD_DATA, PREFIX);
        repeat (5) begin bus.HOST_RD = 1; tick(); end
        chk("tp_drained", bus.HOST_RD_VALID, 0);

        // Junk word then zero-length frame
        mw(16'h1234);
        chk("tp_err_pulse", bus.FRAME_ERR, 1);
        mw(PREFIX);
        chk("tp_err_cleared", bus.FRAME_ERR, 0);
        mw(16'h0000);
        chk("tp_fc_two", bus.FRAME_COUNT, 2);
        drain();

        // Fill IN endpoint to auto-commit, then overflow
        repeat (PKT_WORDS - 1) mw(rand_word());
        chk("tp_no_commit_255", bus.HOST_RD_VALID, 0);
        mw(rand_word());
        chk("tp_commit_256", bus.HOST_RD_VALID, 1);
        chk("tp_full", bus.FLAG_FULL, 1);
        chk("tp_no_overflow_yet", bus.OVERFLOW, 0);
        mw(16'hDEAD);
        chk("tp_overflow", bus.OVERFLOW, 1);

        // Simultaneous host pop and master write keep the IN count
        bus.HOST_RD = 1; tick();
        bus.HOST_RD = 1; bus.SLWR = 1; bus.FIFOADR = 2'b10; fd_val = 16'h5A5A; tick();
        chk("tp_same_edge_full", bus.FLAG_FULL, 0);
        bus.SLWR = 1; bus.FIFOADR = 2'b10; fd_val = 16'h6B6B; tick();
        chk("tp_refull", bus.FLAG_FULL, 1);
        drain();

        // Reset in the middle of a frame
        bus.HOST_WR = 1; bus.HOST_WR_DATA = 16'h7777; tick();
        mw(PREFIX); mw(16'h0005); mw(16'h0001); mw(16'h0002);
        RST = 1;
        #1;
        model_reset();
        chk("rst_empty", bus.FLAG_EMPTY, 1);
        chk("rst_fc", bus.FRAME_COUNT, 0);
        chk("rst_full", bus.FLAG_FULL, 0);
        chk("rst_valid", bus.HOST_RD_VALID, 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 0;
        mw(16'h0003);
        chk("rst_parser_hunt", bus.FRAME_ERR, 1);

        // Randomized traffic in two phases: host-drain heavy, then master-write heavy
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                bus.SLOE         = 1'($urandom % 2);
                bus.FIFOADR      = ($urandom % 8 < 3) ? 2'b00 : ($urandom % 8 < 7 ? 2'b10 : 2'($urandom));
                bus.SLRD         = ($urandom % 3) == 0;
                bus.SLWR         = ($urandom % 4) != 0;
                bus.PKTEND       = ($urandom % 24) == 0;
                bus.HOST_WR      = ($urandom % 2) == 0;
                bus.HOST_WR_DATA = 16'($urandom);
                bus.HOST_RD      = ph == 0 ? ($urandom % 2) == 0 : ($urandom % 16) == 0;
                fd_val           = rand_word();
                tick();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
